instr_queue: RTL and testbench

Instruction fetch queue for the out-of-order RISC-V core, directly upstream of the memory fetcher. It generates sequential PCs, issues one instruction-fetch request at a time to the fetcher, and captures the returned 32-bit instruction words in a circular FIFO. The FIFO feeds the decoder. On a ROB exception/redirect it flushes all buffered instructions, restarts at the new PC and discards any response already in flight.

---
 rtl/instr_queue_if.sv | 52 +++++
 rtl/instr_queue.sv | 137 +++++++++++++
 tb/tb_instr_queue.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_queue_if.sv
// ---------------------------------------------------------------------------
// instr_queue_if
// Groups the fetcher, ROB and decoder signals of the instruction fetch queue.
//   slave  : the queue itself (consumes fetcher/ROB/decoder inputs,
//            drives the fetch request and the decoder head entry)
//   master : the surrounding core (fetcher, ROB, decoder) or a testbench
// Signals:
//   is_stall_from_fc      fetcher request buffer full
//   is_finish_from_fc     one-cycle transaction-complete pulse
//   is_instr_from_fc      completing transaction is an instruction fetch
//   data_from_fc          fetched instruction word
//   addr_from_fc          address of the completed transaction
//   is_exception_from_rob redirect/flush request
//   pc_from_rob           restart PC
//   is_receive_from_dec   decoder pops the head entry
//   is_empty_to_fc        low while a fetch request is offered
//   addr_to_fc            fetch address
//   is_empty_to_dec       FIFO empty
//   instr_to_dec          head instruction word
//   pc_to_dec             head instruction PC
// ---------------------------------------------------------------------------
interface instr_queue_if;
    logic        is_stall_from_fc;
    logic        is_finish_from_fc;
    logic        is_instr_from_fc;
    logic [31:0] data_from_fc;
    logic [31:0] addr_from_fc;
    logic        is_exception_from_rob;
    logic [31:0] pc_from_rob;
    logic        is_receive_from_dec;
    logic        is_empty_to_fc;
    logic [31:0] addr_to_fc;
    logic        is_empty_to_dec;
    logic [31:0] instr_to_dec;
    logic [31:0] pc_to_dec;

    modport slave (
        input  is_stall_from_fc, is_finish_from_fc, is_instr_from_fc,
               data_from_fc, addr_from_fc, is_exception_from_rob,
               pc_from_rob, is_receive_from_dec,
        output is_empty_to_fc, addr_to_fc, is_empty_to_dec,
               instr_to_dec, pc_to_dec
    );

    modport master (
        output is_stall_from_fc, is_finish_from_fc, is_instr_from_fc,
               data_from_fc, addr_from_fc, is_exception_from_rob,
               pc_from_rob, is_receive_from_dec,
        input  is_empty_to_fc, addr_to_fc, is_empty_to_dec,
               instr_to_dec, pc_to_dec
    );
endinterface

// File: rtl/instr_queue.sv
// ---------------------------------------------------------------------------
// instr_queue
// Instruction fetch queue: generates sequential PCs, issues one fetch request
// at a time, and buffers returned instruction words (with their PCs) in a
// 16-entry circular FIFO feeding the decoder. A ROB exception flushes the
// FIFO, restarts at the ROB PC and drops any response still in flight.
// Ports:
//   clk  : clock, all state changes on rising edge
//   rst  : asynchronous active-low reset
//   bus  : instr_queue_if.slave (fetcher, ROB and decoder signals)
// ---------------------------------------------------------------------------
module instr_queue #(
    parameter int unsigned QueueLength   = 15,
    parameter int unsigned PointerLength = 3,
    parameter int unsigned CountLength   = 4,
    parameter logic [31:0] ResetPc       = 32'h0
) (
    input  logic          clk,
    input  logic          rst,
    instr_queue_if.slave  bus
);
    localparam int unsigned Depth = QueueLength + 1;
    localparam logic [CountLength:0] FullCount = (CountLength + 1)'(Depth);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_e;

    state_e                 state_q, state_d;
    logic [31:0]            pc_q, pc_d;
    logic [31:0]            addr_q, addr_d;
    logic [PointerLength:0] head_q, head_d;
    logic [PointerLength:0] tail_q, tail_d;
    logic [CountLength:0]   count_q, count_d;
    logic [31:0]            instr_mem_q [Depth];
    logic [31:0]            pc_mem_q    [Depth];

    logic instr_done;
    logic push;
    logic pop;

    // Only instruction-fetch completions matter; SLB completions are ignored.
    assign instr_done = bus.is_finish_from_fc & bus.is_instr_from_fc;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        push    = 1'b0;
        pop     = 1'b0;

        if (bus.is_exception_from_rob) begin
            // Flush wins over everything; a same-edge push or pop is void.
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            pc_d    = bus.pc_from_rob;
            case (state_q)
                // An unstalled REQ is accepted at this very edge.
                REQ:     state_d = bus.is_stall_from_fc ? IDLE : DROP;
                // A same-edge finish consumes the in-flight response.
                WAIT:    state_d = instr_done ? IDLE : DROP;
                DROP:    state_d = instr_done ? IDLE : DROP;
                default: state_d = IDLE;
            endcase
        end else begin
            push = (state_q == WAIT) && instr_done;
            pop  = bus.is_receive_from_dec && (count_q != '0);
            case (state_q)
                IDLE: begin
                    if (count_q != FullCount) begin
                        state_d = REQ;
                        addr_d  = pc_q;
                    end
                end
                REQ: begin
                    if (!bus.is_stall_from_fc) state_d = WAIT;
                end
                WAIT: begin
                    if (instr_done) begin
                        state_d = IDLE;
                        pc_d    = pc_q + 32'd4;
                    end
                end
                default: begin
                    if (instr_done) state_d = IDLE;
                end
            endcase
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= ResetPc;
            addr_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            // NOTE: the entries are reset because the head entry is visible
            // to the decoder and must read as zero out of reset.
            for (int i = 0; i < int'(Depth); i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values.
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push) begin
                instr_mem_q[tail_q] <= bus.data_from_fc;
                pc_mem_q[tail_q]    <= bus.addr_from_fc;
            end
        end
    end

    assign bus.is_empty_to_fc  = (state_q != REQ);
    assign bus.addr_to_fc      = addr_q;
    assign bus.is_empty_to_dec = (count_q == '0);
    assign bus.instr_to_dec    = instr_mem_q[head_q];
    assign bus.pc_to_dec       = pc_mem_q[head_q];
endmodule

// File: tb/tb_instr_queue.sv
// ---------------------------------------------------------------------------
// tb_instr_queue
// Directed testbench for instr_queue. The bench plays fetcher, ROB and
// decoder through the interface; inputs change 1 time unit after a rising
// edge and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_instr_queue;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    localparam logic [31:0] Nop  = 32'h0000_0013;
    localparam logic [31:0] EBase = 32'hFFFF_FFC0;

    instr_queue_if bus ();

    instr_queue dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serve one fetch: wait for the request, accept it unstalled, return the
    // word six edges later. Optionally pop the head on the finish edge.
    task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] data,
                         input bit pop_at_finish);
        int waited = 0;
        while (bus.is_empty_to_fc === 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        check("req offered", {31'd0, bus.is_empty_to_fc}, 32'd0);
        check("req addr", bus.addr_to_fc, exp_addr);
        bus.is_stall_from_fc = 1'b0;
        tick();
        bus.is_stall_from_fc = 1'b1;
        check("req accepted", {31'd0, bus.is_empty_to_fc}, 32'd1);
        repeat (5) tick();
        bus.is_finish_from_fc   = 1'b1;
        bus.is_instr_from_fc    = 1'b1;
        bus.data_from_fc        = data;
        bus.addr_from_fc        = exp_addr;
        bus.is_receive_from_dec = pop_at_finish;
        tick();
        bus.is_finish_from_fc   = 1'b0;
        bus.is_instr_from_fc    = 1'b0;
        bus.is_receive_from_dec = 1'b0;
        check("push visible", {31'd0, bus.is_empty_to_dec}, 32'd0);
        check("idle after push", {31'd0, bus.is_empty_to_fc}, 32'd1);
    endtask

    task automatic pop_expect(input logic [31:0] exp_pc, input logic [31:0] exp_instr);
        check("head pc", bus.pc_to_dec, exp_pc);
        check("head instr", bus.instr_to_dec, exp_instr);
        bus.is_receive_from_dec = 1'b1;
        tick();
        bus.is_receive_from_dec = 1'b0;
    endtask

    task automatic expect_no_req(input int cycles, input string tag);
        bit seen = 1'b0;
        repeat (cycles) begin
            tick();
            if (bus.is_empty_to_fc !== 1'b1) seen = 1'b1;
        end
        check(tag, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        bus.is_stall_from_fc      = 1'b1;
        bus.is_finish_from_fc     = 1'b0;
        bus.is_instr_from_fc      = 1'b0;
        bus.data_from_fc          = '0;
        bus.addr_from_fc          = '0;
        bus.is_exception_from_rob = 1'b0;
        bus.pc_from_rob           = '0;
        bus.is_receive_from_dec   = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst empty_to_fc", {31'd0, bus.is_empty_to_fc}, 32'd1);
        check("rst addr_to_fc", bus.addr_to_fc, 32'd0);
        check("rst empty_to_dec", {31'd0, bus.is_empty_to_dec}, 32'd1);
        check("rst instr_to_dec", bus.instr_to_dec, 32'd0);
        check("rst pc_to_dec", bus.pc_to_dec, 32'd0);
        rst = 1'b1;
        tick();
        check("cycle1 req", {31'd0, bus.is_empty_to_fc}, 32'd0);
        check("cycle1 addr", bus.addr_to_fc, 32'd0);

        // Sequential fetch 0, 4, 8 then decode in order
        fetch(32'd0, Nop, 1'b0);
        fetch(32'd4, Nop, 1'b0);
        fetch(32'd8, Nop, 1'b0);
        pop_expect(32'd0, Nop);
        pop_expect(32'd4, Nop);
        pop_expect(32'd8, Nop);
        check("drained", {31'd0, bus.is_empty_to_dec}, 32'd1);

        // Stall held for 5 cycles during REQ
        repeat (5) begin
            tick();
            check("stall req held", {31'd0, bus.is_empty_to_fc}, 32'd0);
            check("stall addr held", bus.addr_to_fc, 32'd12);
        end
        fetch(32'd12, 32'h0010_0093, 1'b0);
        pop_expect(32'd12, 32'h0010_0093);

        // SLB finish during WAIT is ignored
        fetch_accept_only(32'd16);
        repeat (2) tick();
        bus.is_finish_from_fc = 1'b1;
        bus.is_instr_from_fc  = 1'b0;
        bus.data_from_fc      = 32'hDEAD_BEEF;
        bus.addr_from_fc      = 32'h0000_0040;
        tick();
        bus.is_finish_from_fc = 1'b0;
        check("slb ignored fifo", {31'd0, bus.is_empty_to_dec}, 32'd1);
        check("slb ignored fsm", {31'd0, bus.is_empty_to_fc}, 32'd1);
        repeat (2) tick();
        bus.is_finish_from_fc = 1'b1;
        bus.is_instr_from_fc  = 1'b1;
        bus.data_from_fc      = 32'h0020_0113;
        bus.addr_from_fc      = 32'd16;
        tick();
        bus.is_finish_from_fc = 1'b0;
        bus.is_instr_from_fc  = 1'b0;
        check("instr captured pc", bus.pc_to_dec, 32'd16);
        check("instr captured word", bus.instr_to_dec, 32'h0020_0113);

        // Exception while WAIT: flush, drop in-flight response, restart
        fetch_accept_only(32'd20);
        repeat (2) tick();
        bus.is_exception_from_rob = 1'b1;
        bus.pc_from_rob           = 32'h0000_1000;
        tick();
        bus.is_exception_from_rob = 1'b0;
        check("exc flushed", {31'd0, bus.is_empty_to_dec}, 32'd1);
        check("exc no req", {31'd0, bus.is_empty_to_fc}, 32'd1);
        repeat (3) tick();
        bus.is_finish_from_fc = 1'b1;
        bus.is_instr_from_fc  = 1'b1;
        bus.data_from_fc      = Nop;
        bus.addr_from_fc      = 32'd20;
        tick();
        bus.is_finish_from_fc = 1'b0;
        bus.is_instr_from_fc  = 1'b0;
        check("drop discarded", {31'd0, bus.is_empty_to_dec}, 32'd1);
        check("drop no req yet", {31'd0, bus.is_empty_to_fc}, 32'd1);
        tick();
        check("restart req", {31'd0, bus.is_empty_to_fc}, 32'd0);
        check("restart addr", bus.addr_to_fc, 32'h0000_1000);

        // Fill to 16 without popping; no request while full
        for (int i = 0; i < 16; i++) begin
            fetch(32'h0000_1000 + 32'(4 * i), 32'hA000_0000 | 32'(i), 1'b0);
        end
        expect_no_req(10, "full no req");
        pop_expect(32'h0000_1000, 32'hA000_0000);
        fetch(32'h0000_1040, 32'hA000_0010, 1'b0);
        expect_no_req(10, "one pop one req");
        check("head after refill", bus.pc_to_dec, 32'h0000_1004);

        // Flush, refill across pc wrap, push+pop on same edge, drain
        bus.is_exception_from_rob = 1'b1;
        bus.pc_from_rob           = EBase;
        tick();
        bus.is_exception_from_rob = 1'b0;
        check("flush full", {31'd0, bus.is_empty_to_dec}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            logic [31:0] a;
            a = EBase + 32'(4 * i);
            fetch(a, ~a, 1'b0);
        end
        expect_no_req(5, "wrap full no req");
        pop_expect(EBase, ~EBase);
        fetch(32'd0, 32'hFFFF_FFFF, 1'b1);
        fetch(32'd4, 32'hFFFF_FFFB, 1'b0);
        expect_no_req(5, "push pop count kept");
        for (int i = 2; i < 16; i++) begin
            logic [31:0] a;
            a = EBase + 32'(4 * i);
            pop_expect(a, ~a);
        end
        pop_expect(32'd0, 32'hFFFF_FFFF);
        pop_expect(32'd4, 32'hFFFF_FFFB);
        check("final empty", {31'd0, bus.is_empty_to_dec}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Wait for a request and accept it, leaving the response to the caller.
    task automatic fetch_accept_only(input logic [31:0] exp_addr);
        int waited = 0;
        while (bus.is_empty_to_fc === 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        check("req offered", {31'd0, bus.is_empty_to_fc}, 32'd0);
        check("req addr", bus.addr_to_fc, exp_addr);
        bus.is_stall_from_fc = 1'b0;
        tick();
        bus.is_stall_from_fc = 1'b1;
        check("req accepted", {31'd0, bus.is_empty_to_fc}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule
